// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared FSM states and word geometry for the instruction-memory loader
package instr_mem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_CHK,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// rtl/instr_mem_loader_byte_packer.sv - 8-to-32 little-endian byte packer with lane counter
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [31:0]           word_q;

  // Merge the incoming byte into its lane so the completed word is available on the 4th transfer.
  always_comb begin
    word_next = word_q;
    word_next[{byte_cnt, 3'b000} +: 8] = byte_in;
  end

  assign word_full = shift_en && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  // Lane counter wraps after the last lane, so each word starts in lane 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (shift_en) begin
      byte_cnt <= byte_cnt + 1'b1;
      word_q   <= word_next;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream program loader into instruction memory, optional LOADER_CHECKSUM_EN
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                LEN_W     = 16,
  parameter int                MAX_WORDS = 64
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic              chk_err
);

  loader_state_t    state, next_state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_idx;
  logic [31:0]      word_next;
  logic             word_full;
  logic             len_too_big;
  logic             last_word;
  logic             accept_start;

  assign len_too_big  = len_words > LEN_W'(MAX_WORDS);
  assign last_word    = word_idx == (len_q - LEN_W'(1));
  assign accept_start = (state == ST_IDLE) && start && !len_too_big;

  instr_mem_loader_byte_packer u_packer (
    .clk       (CLK),
    .reset     (Reset),
    .shift_en  ((state == ST_LOAD) && byte_valid),
    .byte_in   (byte_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len_words == '0)   next_state = ST_DONE;
          else if (!len_too_big) next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_full) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = ST_CHK;
`else
          next_state = ST_DONE;
`endif
        end else begin
          next_state = ST_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) next_state = ST_DONE;
      end
`endif
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Length latch, word counter, write port registers, core reset and length-error pulse.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      len_q      <= '0;
      word_idx   <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_reset <= 1'b1;
      len_err    <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && len_too_big) begin
            len_err <= 1'b1;
          end else if (accept_start && (len_words != '0)) begin
            len_q      <= len_words;
            word_idx   <= '0;
            core_reset <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (word_full) begin
            wr_addr <= BASE_ADDR + (ADDR_W'(word_idx) << 2);
            wr_data <= word_next;
          end
        end
        ST_WRITE: begin
          if (!last_word) word_idx <= word_idx + LEN_W'(1);
        end
        ST_DONE:  core_reset <= chk_err;
        default:  ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       chk_err_q;

  // Running byte sum; the trailing checksum byte must bring it to zero mod 256.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else if (accept_start) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else if ((state == ST_LOAD) && byte_valid) begin
      sum_q <= sum_q + byte_data;
    end else if ((state == ST_CHK) && byte_valid) begin
      chk_err_q <= (sum_q + byte_data) != 8'h00;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  localparam int MAX_WORDS = 64;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len_words = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, wr_en, core_reset, busy, done, len_err, chk_err;
  logic [31:0] wr_addr, wr_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  prog [0:4*MAX_WORDS-1];
  logic [31:0] obs_addr [$];
  logic [31:0] obs_data [$];
  int          done_cnt  = 0;
  int          ready_err = 0;

  always #5 CLK = ~CLK;

  instr_mem_loader dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .start      (start),
    .len_words  (len_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .len_err    (len_err),
    .chk_err    (chk_err)
  );

  always @(negedge CLK) begin
    if (wr_en) begin
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
      if (byte_ready) ready_err++;
    end
    if (done) done_cnt++;
  end

  function automatic logic [31:0] exp_word(input int i);
    return {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  n = 0;
    bit  rdy;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(posedge CLK); #1;
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    forever begin
      @(negedge CLK);
      rdy = byte_ready;
      @(posedge CLK); #1;
      if (rdy) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL byte_timeout: byte_ready never high, required a transfer");
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output logic cr);
    seen = 1'b0;
    cr   = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        cr   = core_reset;
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic run_load(input int len, input bit gaps, input bit poke, input bit bad_chk,
                          output bit seen, output logic cr);
    logic [7:0] sum = '0;
    obs_addr.delete();
    obs_data.delete();
    done_cnt  = 0;
    len_words = 16'(len);
    start     = 1'b1;
    @(posedge CLK); #1;
    start = poke;
    for (int k = 0; k < 4*len; k++) begin
      send_byte(prog[k], gaps);
      sum = sum + prog[k];
      if (k == 2) start = 1'b0;
    end
    start = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_chk ? 8'(8'h00 - sum - 8'h01) : 8'(8'h00 - sum), gaps);
`else
    if (bad_chk) sum = '0;
`endif
    wait_done(seen, cr);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if ({byte_ready, wr_en, busy, done, len_err, chk_err, core_reset} !== 7'b0000001 ||
        wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got rdy/wr/busy/done/lerr/cerr/crst=%b addr=%h data=%h, required 0000001 0 0",
               {byte_ready, wr_en, busy, done, len_err, chk_err, core_reset}, wr_addr, wr_data);
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  task automatic test_basic;
    bit seen; logic cr;
    prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h10; prog[7] = 8'h00;
    run_load(2, 1'b0, 1'b0, 1'b0, seen, cr);
    checks++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 32'h0 || obs_data[0] !== 32'h00000013 ||
        obs_addr[1] !== 32'h4 || obs_data[1] !== 32'h00100093) begin
      errors++;
      $display("FAIL basic_writes: got %0d writes, first %h/%h, required 2 writes 0/00000013 4/00100093",
               obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 32'hx, obs_data.size() > 0 ? obs_data[0] : 32'hx);
    end
    checks++;
    if (!seen || done_cnt != 1 || cr !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: seen=%0d count=%0d core_reset_during_done=%b, required 1 1 1", seen, done_cnt, cr);
    end
    checks++;
    if (core_reset !== 1'b0 || busy !== 1'b0 || chk_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: core_reset=%b busy=%b chk_err=%b, required 0 0 0", core_reset, busy, chk_err);
    end
  endtask

  task automatic test_random_stall;
    bit seen; logic cr;
    for (int r = 0; r < 3; r++) begin
      int len = $urandom_range(1, 6);
      for (int k = 0; k < 4*len; k++) prog[k] = 8'($urandom);
      ready_err = 0;
      run_load(len, 1'b1, 1'b0, 1'b0, seen, cr);
      checks++;
      if (obs_addr.size() != len || !seen || done_cnt != 1) begin
        errors++;
        $display("FAIL stall_count: writes=%0d done=%0d, required %0d 1", obs_addr.size(), done_cnt, len);
      end
      for (int i = 0; i < len && i < obs_addr.size(); i++) begin
        checks++;
        if (obs_addr[i] !== 32'(4*i) || obs_data[i] !== exp_word(i)) begin
          errors++;
          $display("FAIL stall_word%0d: got %h/%h, required %h/%h", i, obs_addr[i], obs_data[i], 32'(4*i), exp_word(i));
        end
      end
      checks++;
      if (ready_err != 0) begin
        errors++;
        $display("FAIL ready_in_write: byte_ready high during wr_en %0d times, required 0", ready_err);
      end
    end
  endtask

  task automatic test_len_bounds;
    obs_addr.delete();
    obs_data.delete();
    len_words = 16'd0;
    start     = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    checks++;
    if (done !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL len_zero: done=%b wr_en=%b, required 1 0", done, wr_en);
    end
    @(posedge CLK); #1;
    len_words = 16'(MAX_WORDS + 1);
    start     = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    checks++;
    if (len_err !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL len_over: len_err=%b busy=%b byte_ready=%b, required 1 0 0", len_err, busy, byte_ready);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (len_err !== 1'b0 || busy !== 1'b0 || obs_addr.size() != 0) begin
      errors++;
      $display("FAIL len_over_after: len_err=%b busy=%b writes=%0d, required 0 0 0", len_err, busy, obs_addr.size());
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_max_len;
    bit seen; logic cr;
    int bad = 0;
    for (int k = 0; k < 4*MAX_WORDS; k++) prog[k] = 8'($urandom);
    run_load(MAX_WORDS, 1'b0, 1'b0, 1'b0, seen, cr);
    for (int i = 0; i < MAX_WORDS && i < obs_addr.size(); i++)
      if (obs_addr[i] !== 32'(4*i) || obs_data[i] !== exp_word(i)) bad++;
    checks++;
    if (obs_addr.size() != MAX_WORDS || bad != 0 || !seen) begin
      errors++;
      $display("FAIL max_len: writes=%0d bad=%0d done=%0d, required %0d 0 1", obs_addr.size(), bad, seen, MAX_WORDS);
    end
  endtask

  task automatic test_reset_mid_load;
    bit seen; logic cr;
    for (int k = 0; k < 12; k++) prog[k] = 8'($urandom);
    obs_addr.delete();
    obs_data.delete();
    len_words = 16'd3;
    start     = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int k = 0; k < 6; k++) send_byte(prog[k], 1'b0);
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs_addr.size() != 1 || obs_data[0] !== exp_word(0) || busy !== 1'b0 ||
        core_reset !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: writes=%0d busy=%b core_reset=%b byte_ready=%b, required 1 0 1 0",
               obs_addr.size(), busy, core_reset, byte_ready);
    end
    @(posedge CLK); #1;
    run_load(3, 1'b0, 1'b0, 1'b0, seen, cr);
    checks++;
    if (obs_addr.size() != 3 || !seen) begin
      errors++;
      $display("FAIL restart_count: writes=%0d done=%0d, required 3 1", obs_addr.size(), seen);
    end
    for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== 32'(4*i) || obs_data[i] !== exp_word(i)) begin
        errors++;
        $display("FAIL restart_word%0d: got %h/%h, required %h/%h", i, obs_addr[i], obs_data[i], 32'(4*i), exp_word(i));
      end
    end
  endtask

  task automatic test_start_during_load;
    bit seen; logic cr;
    int bad = 0;
    for (int k = 0; k < 8; k++) prog[k] = 8'($urandom);
    run_load(2, 1'b1, 1'b1, 1'b0, seen, cr);
    for (int i = 0; i < 2 && i < obs_addr.size(); i++)
      if (obs_addr[i] !== 32'(4*i) || obs_data[i] !== exp_word(i)) bad++;
    checks++;
    if (obs_addr.size() != 2 || bad != 0 || done_cnt != 1 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: writes=%0d bad=%0d done=%0d core_reset=%b, required 2 0 1 0",
               obs_addr.size(), bad, done_cnt, core_reset);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    bit seen; logic cr;
    prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03; prog[3] = 8'h04;
    run_load(1, 1'b0, 1'b0, 1'b0, seen, cr);
    checks++;
    if (chk_err !== 1'b0 || core_reset !== 1'b0 || !seen || obs_data.size() != 1 || obs_data[0] !== 32'h04030201) begin
      errors++;
      $display("FAIL chk_good: chk_err=%b core_reset=%b done=%0d, required 0 0 1", chk_err, core_reset, seen);
    end
    run_load(1, 1'b0, 1'b0, 1'b1, seen, cr);
    checks++;
    if (chk_err !== 1'b1 || core_reset !== 1'b1 || !seen) begin
      errors++;
      $display("FAIL chk_bad: chk_err=%b core_reset=%b done=%0d, required 1 1 1", chk_err, core_reset, seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random_stall();
    test_len_bounds();
    test_max_len();
    test_reset_mid_load();
    test_start_during_load();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
